// File: rtl/rs_alu.sv
// ALU reservation station: buffers issued ALU-class instructions, snoops the
// ALU and LSB result broadcasts to wake waiting operands, and sends at most one
// ready entry per cycle to the ALU operand registers.
module rs_alu #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned OP_W    = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [31:0]      issue_vj,
  input  logic             issue_qj_wait,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qk_wait,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic [ROB_W-1:0] issue_robid,
  output logic             rs_full,
  input  logic             alu_valid,
  input  logic [31:0]      alu_result,
  input  logic [ROB_W-1:0] alu_robid,
  input  logic             lsb_valid,
  input  logic [31:0]      lsb_result,
  input  logic [ROB_W-1:0] lsb_robid,
  input  logic             rob_clear,
  output logic [31:0]      out_rs1,
  output logic [31:0]      out_rs2,
  output logic [OP_W-1:0]  out_op,
  output logic [ROB_W-1:0] out_robid
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic             qj_wait;
    logic [ROB_W-1:0] qj;
    logic [31:0]      vk;
    logic             qk_wait;
    logic [ROB_W-1:0] qk;
    logic [ROB_W-1:0] robid;
  } entry_t;

  entry_t           ent_q [RS_SIZE];
  entry_t           ent_d [RS_SIZE];
  logic [31:0]      out_rs1_q, out_rs1_d;
  logic [31:0]      out_rs2_q, out_rs2_d;
  logic [OP_W-1:0]  out_op_q, out_op_d;
  logic [ROB_W-1:0] out_robid_q, out_robid_d;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             disp_found;
  logic [IDX_W-1:0] disp_idx;
  entry_t           new_ent;

  // Lowest free slot and lowest ready slot, both from registered state only
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!free_found && !ent_q[i].busy) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!disp_found && ent_q[i].busy && !ent_q[i].qj_wait && !ent_q[i].qk_wait) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
    end
  end

  assign rs_full = ~free_found;

  // Incoming entry with same-cycle broadcast bypass; ALU match wins over LSB
  always_comb begin
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.op      = issue_op;
    new_ent.vj      = issue_vj;
    new_ent.qj_wait = issue_qj_wait;
    new_ent.qj      = issue_qj;
    new_ent.vk      = issue_vk;
    new_ent.qk_wait = issue_qk_wait;
    new_ent.qk      = issue_qk;
    new_ent.robid   = issue_robid;
    if (issue_qj_wait) begin
      if (alu_valid && issue_qj == alu_robid) begin
        new_ent.vj      = alu_result;
        new_ent.qj_wait = 1'b0;
      end else if (lsb_valid && issue_qj == lsb_robid) begin
        new_ent.vj      = lsb_result;
        new_ent.qj_wait = 1'b0;
      end
    end
    if (issue_qk_wait) begin
      if (alu_valid && issue_qk == alu_robid) begin
        new_ent.vk      = alu_result;
        new_ent.qk_wait = 1'b0;
      end else if (lsb_valid && issue_qk == lsb_robid) begin
        new_ent.vk      = lsb_result;
        new_ent.qk_wait = 1'b0;
      end
    end
  end

  // Next state: flush, wakeup, dispatch and issue
  always_comb begin
    ent_d       = ent_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_robid_d = out_robid_q;
    out_op_d    = '0;
    if (rob_clear) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        ent_d[i].busy = 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy && ent_q[i].qj_wait) begin
          if (alu_valid && ent_q[i].qj == alu_robid) begin
            ent_d[i].vj      = alu_result;
            ent_d[i].qj_wait = 1'b0;
          end else if (lsb_valid && ent_q[i].qj == lsb_robid) begin
            ent_d[i].vj      = lsb_result;
            ent_d[i].qj_wait = 1'b0;
          end
        end
        if (ent_q[i].busy && ent_q[i].qk_wait) begin
          if (alu_valid && ent_q[i].qk == alu_robid) begin
            ent_d[i].vk      = alu_result;
            ent_d[i].qk_wait = 1'b0;
          end else if (lsb_valid && ent_q[i].qk == lsb_robid) begin
            ent_d[i].vk      = lsb_result;
            ent_d[i].qk_wait = 1'b0;
          end
        end
      end
      if (rdy_in) begin
        // the dispatched slot is busy and the issue slot is free, so they never collide
        if (disp_found) begin
          out_rs1_d           = ent_q[disp_idx].vj;
          out_rs2_d           = ent_q[disp_idx].vk;
          out_op_d            = ent_q[disp_idx].op;
          out_robid_d         = ent_q[disp_idx].robid;
          ent_d[disp_idx].busy = 1'b0;
        end
        if (issue_valid && free_found) begin
          ent_d[free_idx] = new_ent;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_op_q    <= '0;
      out_robid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_op_q    <= out_op_d;
      out_robid_q <= out_robid_d;
    end
  end

  assign out_rs1   = out_rs1_q;
  assign out_rs2   = out_rs2_q;
  assign out_op    = out_op_q;
  assign out_robid = out_robid_q;

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station for the ALU in the Tomasulo core. It buffers decoded ALU-class instructions from the issue stage.
- It snoops the ALU and LSB result broadcasts to wake up waiting operands.
- Each cycle it dispatches at most one ready entry to the ALU's rs1/rs2/op/robid inputs.
- It is the initiator side of the ALU operand interface. Its own ALU broadcast is fed back into its wakeup logic.

Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥2)
- ROB_W, 4, RoB tag width (equals `RoB_addr)
- OP_W, 6, op code width; op 0 means "no operation"

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous reset, active-low
- rdy_in  in  1  global ready; low = pause
- issue_valid  in  1  new instruction this cycle
- issue_op  in  OP_W  ALU op (`Add, `Beq, ...; nonzero)
- issue_vj  in  32  operand 1 value (valid when issue_qj_wait=0)
- issue_qj_wait  in  1  operand 1 pending on a RoB tag
- issue_qj  in  ROB_W  operand 1 producer tag
- issue_vk  in  32  operand 2 value
- issue_qk_wait  in  1  operand 2 pending
- issue_qk  in  ROB_W  operand 2 producer tag
- issue_robid  in  ROB_W  destination RoB tag
- rs_full  out  1  no free entry (combinational from registered occupancy)
- alu_valid  in  1  ALU broadcast valid
- alu_result  in  32  ALU broadcast value
- alu_robid  in  ROB_W  ALU broadcast tag
- lsb_valid  in  1  LSB broadcast valid
- lsb_result  in  32  LSB broadcast value
- lsb_robid  in  ROB_W  LSB broadcast tag
- rob_clear  in  1  mispredict flush
- out_rs1  out  32  to ALU rs1 (registered)
- out_rs2  out  32  to ALU rs2 (registered)
- out_op  out  OP_W  to ALU op (registered; 0 = idle)
- out_robid  out  ROB_W  to ALU robid (registered)

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All entries invalid.
  - out_op=0, out_rs1=0, out_rs2=0, out_robid=0, rs_full=0.
- Entry state: busy, op, vj, qj_wait, qj, vk, qk_wait, qk, robid.
- rs_full=1 iff all RS_SIZE entries are busy.
- Issue (rising edge, rdy_in=1, rob_clear=0, issue_valid=1, rs_full=0):
  - The instruction is written into the lowest-index free entry.
  - If issue_valid=1 while rs_full=1, the instruction is dropped. Upstream must not do this; the bench flags it.
- Issue bypass:
  - If an incoming operand is waiting and its tag equals alu_robid (alu_valid=1) or lsb_robid (lsb_valid=1) in the same cycle, the entry stores the broadcast value with wait=0.
  - If ALU and LSB both match, the ALU value wins. Legal streams never produce this case.
- Wakeup (every edge, including rdy_in=0; not during rob_clear):
  - For each busy entry, a waiting operand whose tag matches a valid broadcast captures the result and clears wait.
  - Both operands of one entry may wake in the same cycle.
- Dispatch:
  - Readiness is evaluated on registered entry state: busy and qj_wait=0 and qk_wait=0.
  - The lowest-index ready entry is selected. On the edge: out_rs1<=vj, out_rs2<=vk, out_op<=op, out_robid<=robid, and the entry is freed.
  - If no entry is ready, or rdy_in=0, then out_op<=0. out_rs1, out_rs2 and out_robid hold.
  - An entry issued or woken on edge N is dispatchable at the earliest on edge N+1. Minimum issue-to-ALU latency is therefore 2 edges.
- Same-edge issue and dispatch:
  - A freed slot is not reusable on the same edge.
  - rs_full reflects the registered occupancy only.
- rob_clear=1 (synchronous, has priority over everything except reset):
  - All entries invalid, out_op<=0.
  - Issue and broadcasts in that cycle are ignored.
- rdy_in=0: no issue, no dispatch; wakeups still captured so broadcasts are not lost.
- Data width: all values 32-bit, no arithmetic performed; tags compared at full ROB_W width.

Test Plan:
1. Issue Add (vj=5, vk=7, both ready, robid=3) at edge N -> after edge N+1: out_op=`Add, out_rs1=5, out_rs2=7, out_robid=3. After edge N+2: out_op=0.
2. Issue Sub (qj_wait=1, qj=2, vk=1). Next cycle: alu_valid=1, alu_robid=2, alu_result=0x10 -> the following edge drives out_op=`Sub, out_rs1=0x10, out_rs2=1. No dispatch before the wakeup.
3. Bypass: issue with qk_wait=1, qk=6, in the same cycle as lsb_valid=1, lsb_robid=6, lsb_result=0xABCD -> dispatched next edge with out_rs2=0xABCD.
4. Fill 8 entries waiting on tag 9 -> rs_full=1, and a 9th issue is dropped. Broadcast tag 9 -> entries dispatch in index order 0..7 on consecutive edges, and rs_full drops after the first dispatch.
5. With 3 busy entries, assert rob_clear together with issue_valid -> all entries cleared, out_op=0, no dispatch on later edges, rs_full=0.
6. Entries 2 and 5 both ready; pull rdy_in low for 3 cycles while broadcasting a wakeup for entry 4 -> out_op=0 throughout the pause. Afterwards entries dispatch in order 2, 4, 5. An asynchronous reset asserted mid-stream immediately zeroes all outputs.
